// File: rtl/dino_jump_ctrl.sv
// rtl/dino_jump_ctrl.sv - dino vertical trajectory under fixed-point gravity
// Produces the foot-row position for the sprite renderer, stepped once per physics tick.
module dino_jump_ctrl #(
    parameter int TICK_DIV = 1666667,
    parameter int GROUND_Y = 200,
    parameter int MIN_Y    = 26,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_V    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       jump,
    input  logic       freeze,
    output logic [8:0] pos,
    output logic       airborne,
    output logic       jump_start,
    output logic       landed
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {GROUND, RISE, FALL, DEAD} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic [5:0]         vel, vel_nx;
    logic [8:0]         pos_nx;
    logic               jump_d, jump_pend, pend_nx, rise;
    logic               js_nx, ld_nx;
    logic signed [9:0]  up;
    logic [9:0]         down;
    logic [6:0]         vel_up;

    assign tick   = (cnt == CW'(TICK_DIV - 1));
    assign rise   = jump & ~jump_d;
    assign up     = $signed({1'b0, pos}) - $signed({4'b0, vel});
    assign down   = {1'b0, pos} + {4'b0, vel};
    assign vel_up = {1'b0, vel} + 7'(GRAVITY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= GROUND;
            pos        <= 9'(GROUND_Y);
            vel        <= '0;
            cnt        <= '0;
            jump_pend  <= 1'b0;
            jump_d     <= 1'b0;
            airborne   <= 1'b0;
            jump_start <= 1'b0;
            landed     <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            jump_d     <= jump;
            state      <= state_nx;
            pos        <= pos_nx;
            vel        <= vel_nx;
            jump_pend  <= pend_nx;
            airborne   <= (state_nx == RISE) || (state_nx == FALL);
            jump_start <= js_nx;
            landed     <= ld_nx;
        end
    end

    // freeze is checked first so a collision always wins over a same-cycle tick or jump
    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        vel_nx   = vel;
        pend_nx  = jump_pend;
        js_nx    = 1'b0;
        ld_nx    = 1'b0;
        if (freeze) begin
            state_nx = DEAD;
            pend_nx  = 1'b0;
        end else begin
            case (state)
                GROUND: begin
                    pos_nx = 9'(GROUND_Y);
                    if (rise) pend_nx = 1'b1;
                    if (tick && en && jump_pend) begin
                        vel_nx   = 6'(JUMP_V);
                        pend_nx  = 1'b0;
                        js_nx    = 1'b1;
                        state_nx = RISE;
                    end
                end
                RISE: begin
                    if (tick && en) begin
                        if (up < $signed(10'(MIN_Y))) pos_nx = 9'(MIN_Y);
                        else                          pos_nx = up[8:0];
                        if (vel <= 6'(GRAVITY)) begin
                            vel_nx   = '0;
                            state_nx = FALL;
                        end else begin
                            vel_nx = vel - 6'(GRAVITY);
                        end
                    end
                end
                FALL: begin
                    if (tick && en) begin
                        if (down >= 10'(GROUND_Y)) begin
                            pos_nx   = 9'(GROUND_Y);
                            vel_nx   = '0;
                            ld_nx    = 1'b1;
                            state_nx = GROUND;
                        end else begin
                            pos_nx = down[8:0];
                            vel_nx = (vel_up > 7'(MAX_V)) ? 6'(MAX_V) : vel_up[5:0];
                        end
                    end
                end
                DEAD: begin
                    pend_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb/tb_dino_jump_ctrl.sv - directed bench for dino_jump_ctrl against a behavioural trajectory model
module tb_dino_jump_ctrl;

    localparam int TD = 4, GY = 200, MY = 26, JV = 12, GR = 1, MV = 12;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b1, jump = 1'b0, freeze = 1'b0;
    logic [8:0] pos;
    logic       airborne, jump_start, landed;

    dino_jump_ctrl #(
        .TICK_DIV(TD), .GROUND_Y(GY), .MIN_Y(MY),
        .JUMP_V(JV), .GRAVITY(GR), .MAX_V(MV)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .jump(jump), .freeze(freeze),
        .pos(pos), .airborne(airborne), .jump_start(jump_start), .landed(landed)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // model: mode 0 ground, 1 rising, 2 falling, 3 dead
    int m_cnt = 0, m_pos = GY, m_vel = 0, m_mode = 0;
    bit m_pend = 0, m_jd = 0, m_air = 0, m_js = 0, m_ld = 0;
    bit chk_on = 0;

    always @(posedge clk) begin : model
        bit tk, rs;
        if (rst) begin
            m_cnt = 0; m_pos = GY; m_vel = 0; m_mode = 0;
            m_pend = 0; m_jd = 0; m_air = 0; m_js = 0; m_ld = 0;
        end else begin
            tk = (m_cnt == TD - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            rs = jump && !m_jd;
            m_jd = jump;
            m_js = 0;
            m_ld = 0;
            if (freeze) begin
                m_mode = 3; m_pend = 0;
            end else if (m_mode == 0) begin
                if (tk && en && m_pend) begin
                    m_mode = 1; m_vel = JV; m_pend = 0; m_js = 1;
                end else if (rs) begin
                    m_pend = 1;
                end
            end else if (m_mode == 1 && tk && en) begin
                m_pos = (m_pos - m_vel < MY) ? MY : m_pos - m_vel;
                if (m_vel <= GR) begin m_vel = 0; m_mode = 2; end
                else m_vel = m_vel - GR;
            end else if (m_mode == 2 && tk && en) begin
                if (m_pos + m_vel >= GY) begin
                    m_pos = GY; m_vel = 0; m_ld = 1; m_mode = 0;
                end else begin
                    m_pos = m_pos + m_vel;
                    m_vel = (m_vel + GR > MV) ? MV : m_vel + GR;
                end
            end else if (m_mode == 3) begin
                m_pend = 0;
            end
            m_air = (m_mode == 1 || m_mode == 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pos_vs_model", pos, m_pos);
            chk("airborne_vs_model", airborne, m_air);
            chk("jump_start_vs_model", jump_start, m_js);
            chk("landed_vs_model", landed, m_ld);
        end
    end

    logic [8:0] prev_pos = 9'd200;
    int seq[$];
    int js_cnt = 0, ld_cnt = 0, cyc = 0, js_cyc = 0, ld_cyc = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            cyc++;
            if (jump_start === 1'b1) begin js_cnt++; js_cyc = cyc; end
            if (landed === 1'b1) begin ld_cnt++; ld_cyc = cyc; end
            if (pos !== prev_pos) seq.push_back(int'(pos));
            prev_pos = pos;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int p, input int mode, input int budget);
        int k = 0;
        while (!(pos == 9'(p) && m_mode == mode) && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL wait_pos: got %0d expected %0d within %0d cycles", pos, p, budget);
        end
    endtask

    int exp_traj[24] = '{188, 177, 167, 158, 150, 143, 137, 132, 128, 125, 123, 122,
                         123, 125, 128, 132, 137, 143, 150, 158, 167, 177, 188, 200};

    initial begin
        step(2);
        chk_on = 1;
        rst = 1'b0;

        // idle after reset
        step(50);
        chk("idle_pos", pos, 200);
        chk("idle_airborne", airborne, 0);
        chk("idle_js_cnt", js_cnt, 0);
        chk("idle_ld_cnt", ld_cnt, 0);

        // full jump with key held
        seq.delete(); js_cnt = 0; ld_cnt = 0;
        jump = 1'b1;
        step(200);
        chk("traj_len", seq.size(), 24);
        for (int i = 0; i < 24 && i < seq.size(); i++) chk($sformatf("traj_%0d", i), seq[i], exp_traj[i]);
        chk("held_js_cnt", js_cnt, 1);
        chk("held_ld_cnt", ld_cnt, 1);
        chk("airtime_cycles", ld_cyc - js_cyc, 25 * TD);

        // re-press at apex is discarded
        jump = 1'b0;
        step(3);
        js_cnt = 0; ld_cnt = 0;
        jump = 1'b1;
        wait_until(122, 2, 200);
        chk("apex_airborne", airborne, 1);
        jump = 1'b0;
        step(1);
        jump = 1'b1;
        step(120);
        chk("apex_after_pos", pos, 200);
        chk("apex_js_cnt", js_cnt, 1);
        chk("apex_ld_cnt", ld_cnt, 1);

        // freeze on the tick cycle while rising at 143
        jump = 1'b0;
        step(2);
        jump = 1'b1;
        wait_until(143, 1, 200);
        for (int k = 0; k < TD && m_cnt != TD - 1; k++) @(negedge clk);
        freeze = 1'b1;
        step(1);
        freeze = 1'b0;
        step(30);
        chk("dead_pos", pos, 143);
        chk("dead_airborne", airborne, 0);
        jump = 1'b0;
        step(2);
        jump = 1'b1;
        step(20);
        chk("dead_jump_pos", pos, 143);
        jump = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("dead_rst_pos", pos, 200);
        chk("dead_rst_airborne", airborne, 0);

        // pause mid-rise at 132
        step(5);
        jump = 1'b1;
        wait_until(132, 1, 200);
        en = 1'b0;
        step(40);
        chk("pause_pos", pos, 132);
        chk("pause_airborne", airborne, 1);
        seq.delete();
        en = 1'b1;
        for (int k = 0; k < 40 && seq.size() < 2; k++) @(negedge clk);
        chk("resume_len", seq.size() >= 2, 1);
        if (seq.size() >= 2) begin
            chk("resume_0", seq[0], 128);
            chk("resume_1", seq[1], 125);
        end
        step(80);
        chk("resume_land_pos", pos, 200);

        // reset mid-fall at 158
        jump = 1'b0;
        step(2);
        jump = 1'b1;
        wait_until(158, 2, 200);
        rst = 1'b1;
        jump = 1'b0;
        step(1);
        chk("rst_fall_pos", pos, 200);
        chk("rst_fall_airborne", airborne, 0);
        chk("rst_fall_landed", landed, 0);
        rst = 1'b0;
        step(10);
        chk("rst_fall_idle_pos", pos, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
